scv_snd_cmd_port: RTL
=====================

// Module: scv_snd_cmd_port
// PURPOSE
// - Sound-command responder: accepts CPU write cycles aimed at the sound port
//   (VDC-decoded SCPUB low), buffers the bytes and hands them one by one to the
//   sound engine over a valid/ready stream.
// - Drives ACK back to the CPU interrupt input INT1, one pulse per accepted byte.
// - Sits in scv between the CPU data bus / VDC select and the sound engine.
// PARAMETERS
// - DEPTH    4   FIFO entries; power of two, 2..16
// - ACK_LEN  16  ACK pulse width in CLK cycles, 1..255
// PORTS
// - CLK        in   1  system clock (video XTAL * 2)
// - RESB       in   1  reset, asynchronous, active-low
// - CE         in   1  bus sample strobe (CP1_POSEDGE); bus inputs sampled only when CE=1
// - SCPUB      in   1  sound-port select from VDC, active-low
// - WRB        in   1  CPU write strobe, active-low
// - DB_I       in   8  CPU data bus
// - CMD_DATA   out  8  head-of-FIFO byte
// - CMD_VALID  out  1  CMD_DATA holds a byte
// - CMD_READY  in   1  sound engine consumes the byte when CMD_VALID & CMD_READY
// - ACK        out  1  accept pulse to CPU INT1, active-high
// - FULL       out  1  FIFO holds DEPTH bytes
// - OVF        out  1  sticky: a write arrived while full
// BEHAVIOUR
// - Reset: CMD_DATA=8'h00, CMD_VALID=0, ACK=0, FULL=0, OVF=0, FSM=IDLE, FIFO empty.
//   Reset asserted mid-write or mid-ACK aborts immediately; no byte is kept.
// - Bus FSM (advances only when CE=1):
//   IDLE: SCPUB=0 & WRB=0 -> ARMED; DB_I latched into a holding register.
//   ARMED: while WRB=0, DB_I re-latched on every CE; SCPUB=1 w/o WRB rise -> IDLE, no push.
//          WRB=1 -> COMMIT.
//   COMMIT: one CLK cycle; push held byte if !FULL, else drop and set OVF. -> ACKP (push) or IDLE (drop).
//   ACKP: ACK=1 for ACK_LEN CLK cycles (counted on CLK, not CE), then -> IDLE.
//   A new write seen in ACKP is not captured; the CPU waits for ACK (one command per ACK).
// - FIFO: push in COMMIT, pop on CMD_VALID & CMD_READY, same cycle allowed;
//   simultaneous push+pop when full is legal (pop frees the slot first), occupancy unchanged, no OVF.
// - CMD_VALID = occupancy != 0; CMD_DATA registered, valid same cycle as CMD_VALID.
// - Latency: WRB rise sampled at CE -> COMMIT next CLK -> CMD_VALID and ACK rise 1 CLK later.
// - Pointers wrap modulo DEPTH; occupancy counter is $clog2(DEPTH)+1 bits.
// CONFIGURATION
// - SCV_SNDPORT_STATS_EN defined: adds outputs STAT_ACC[15:0] (bytes pushed) and
//   STAT_DROP[7:0] (bytes dropped); both reset to 0, saturate at all-ones.
// - Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
// - scv_pkg: typedef enum snd_port_state_t {SP_IDLE, SP_ARMED, SP_COMMIT, SP_ACKP};
//   localparam SND_PORT_DEPTH_DEF = 4.
// - One sub-module: scv_sync_fifo (8-bit, DEPTH entries, push/pop/full/empty/count).
// - Top: bus FSM, holding register, ACK counter, OVF flag, optional stats.
// TESTING
// - Single write 8'hA5 (SCPUB=0, WRB low 2 CE periods, CMD_READY=0) -> CMD_VALID=1,
//   CMD_DATA=8'hA5, ACK high exactly ACK_LEN cycles, FULL=0.
// - SCPUB=1 with WRB pulse, data 8'h3C -> no push, ACK stays 0.
// - 5 writes 8'h01..8'h05, DEPTH=4, CMD_READY=0 -> FULL=1 after 4th, OVF=1 after 5th,
//   drain yields 01,02,03,04 in order; 5th gets no ACK.
// - FIFO full, CMD_READY=1 in same cycle as COMMIT of 8'h77 -> count stays 4, OVF=0,
//   8'h77 emerges last.
// - RESB low during ACKP with 2 bytes queued -> all outputs at reset values
//   asynchronously, CMD_VALID=0 after release.
// - SCV_SNDPORT_STATS_EN: 6 writes into DEPTH=4 with CMD_READY=0 -> STAT_ACC=4, STAT_DROP=2.

Source files
------------

// File: rtl/scv_pkg.sv
// Shared types, defaults and helpers for the scv sound-command port.
package scv_pkg;

   typedef enum logic [1:0] {
      SP_IDLE   = 2'd0,
      SP_ARMED  = 2'd1,
      SP_COMMIT = 2'd2,
      SP_ACKP   = 2'd3
   } snd_port_state_t;

   localparam int SND_PORT_DEPTH_DEF   = 4;
   localparam int SND_PORT_ACK_LEN_DEF = 16;

   // Saturating increments for the optional statistics counters.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/scv_snd_cmd_port_if.sv
// CPU-bus / sound-engine signal bundle for scv_snd_cmd_port.
// SCV_SNDPORT_STATS_EN adds the STAT_ACC / STAT_DROP counters to the bundle.
interface scv_snd_cmd_port_if;

   logic       CE;
   logic       SCPUB;
   logic       WRB;
   logic [7:0] DB_I;
   logic [7:0] CMD_DATA;
   logic       CMD_VALID;
   logic       CMD_READY;
   logic       ACK;
   logic       FULL;
   logic       OVF;
`ifdef SCV_SNDPORT_STATS_EN
   logic [15:0] STAT_ACC;
   logic [7:0]  STAT_DROP;

   modport master (
      output CE, SCPUB, WRB, DB_I, CMD_READY,
      input  CMD_DATA, CMD_VALID, ACK, FULL, OVF, STAT_ACC, STAT_DROP
   );
   modport slave (
      input  CE, SCPUB, WRB, DB_I, CMD_READY,
      output CMD_DATA, CMD_VALID, ACK, FULL, OVF, STAT_ACC, STAT_DROP
   );
`else
   modport master (
      output CE, SCPUB, WRB, DB_I, CMD_READY,
      input  CMD_DATA, CMD_VALID, ACK, FULL, OVF
   );
   modport slave (
      input  CE, SCPUB, WRB, DB_I, CMD_READY,
      output CMD_DATA, CMD_VALID, ACK, FULL, OVF
   );
`endif

endinterface

// File: rtl/scv_sync_fifo.sv
// Synchronous FIFO with a registered head-of-queue output; push+pop when full
// is accepted because the pop frees the slot in the same cycle.
module scv_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [W-1:0]           wdata_i,
   output logic [W-1:0]           rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [PW-1:0] rd_ptr_nxt;
   logic [CW-1:0] count_q;
   logic [W-1:0]  head_q;
   logic [W-1:0]  head_d;
   logic          do_push;
   logic          do_pop;

   assign do_pop     = pop_i & (count_q != '0);
   assign do_push    = push_i & ((count_q != CW'(DEPTH)) | do_pop);
   assign rd_ptr_nxt = rd_ptr_q + PW'(1);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= wdata_i;
      end
   end

   // The head register must show the entry that will be at the front after
   // this cycle's push/pop, so an incoming byte bypasses the array when the
   // queue is (or is about to become) empty.
   always_comb begin
      head_d = head_q;
      if (do_pop) begin
         if (count_q > CW'(1)) begin
            head_d = mem[rd_ptr_nxt];
         end else if (do_push) begin
            head_d = wdata_i;
         end
      end else if (do_push && (count_q == '0)) begin
         head_d = wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_nxt;
         end
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
         head_q  <= head_d;
      end
   end

   assign rdata_o = head_q;
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/scv_snd_cmd_port.sv
// Sound-command port: captures CPU writes to the sound port, queues them for the
// sound engine and pulses ACK per accepted byte. SCV_SNDPORT_STATS_EN adds counters.
module scv_snd_cmd_port
   import scv_pkg::*;
#(
   parameter int DEPTH   = SND_PORT_DEPTH_DEF,
   parameter int ACK_LEN = SND_PORT_ACK_LEN_DEF
) (
   input  logic                 CLK,
   input  logic                 RESB,
   scv_snd_cmd_port_if.slave    port_if
);

   localparam int CW = $clog2(DEPTH) + 1;

   localparam logic [1:0] ST_IDLE   = 2'(SP_IDLE);
   localparam logic [1:0] ST_ARMED  = 2'(SP_ARMED);
   localparam logic [1:0] ST_COMMIT = 2'(SP_COMMIT);
   localparam logic [1:0] ST_ACKP   = 2'(SP_ACKP);

   logic [1:0]    state_q;
   logic [1:0]    state_d;
   logic [7:0]    hold_q;
   logic [7:0]    hold_d;
   logic [7:0]    ack_cnt_q;
   logic [7:0]    ack_cnt_d;
   logic          ack_q;
   logic          ack_d;
   logic          ovf_q;
   logic          ovf_d;

   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [7:0]    fifo_head;
   logic          commit_drop;

   assign fifo_pop    = ~fifo_empty & port_if.CMD_READY;
   // A byte committed into a full queue survives only if the engine frees a slot now.
   assign commit_drop = (fifo_count == CW'(DEPTH)) & ~fifo_pop;
   assign fifo_push   = (state_q == ST_COMMIT) & ~commit_drop;

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      ack_cnt_d = ack_cnt_q;
      ack_d     = ack_q;
      ovf_d     = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (port_if.CE && !port_if.SCPUB && !port_if.WRB) begin
               state_d = ST_ARMED;
               hold_d  = port_if.DB_I;
            end
         end
         ST_ARMED: begin
            if (port_if.CE) begin
               if (port_if.WRB) begin
                  state_d = ST_COMMIT;
               end else if (port_if.SCPUB) begin
                  state_d = ST_IDLE;
               end else begin
                  hold_d = port_if.DB_I;
               end
            end
         end
         ST_COMMIT: begin
            if (commit_drop) begin
               ovf_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               ack_d     = 1'b1;
               ack_cnt_d = 8'(ACK_LEN - 1);
               state_d   = ST_ACKP;
            end
         end
         ST_ACKP: begin
            // Timed on CLK, so the pulse width is independent of the CE rate.
            if (ack_cnt_q == '0) begin
               ack_d   = 1'b0;
               state_d = ST_IDLE;
            end else begin
               ack_cnt_d = ack_cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB) begin
         state_q   <= ST_IDLE;
         hold_q    <= '0;
         ack_cnt_q <= '0;
         ack_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         ack_cnt_q <= ack_cnt_d;
         ack_q     <= ack_d;
         ovf_q     <= ovf_d;
      end
   end

   scv_sync_fifo #(
      .DEPTH (DEPTH),
      .W     (8)
   ) u_fifo (
      .clk     (CLK),
      .rst_n   (RESB),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i (hold_q),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign port_if.CMD_DATA  = fifo_head;
   assign port_if.CMD_VALID = ~fifo_empty;
   assign port_if.FULL      = fifo_full;
   assign port_if.ACK       = ack_q;
   assign port_if.OVF       = ovf_q;

`ifdef SCV_SNDPORT_STATS_EN
   logic [15:0] stat_acc_q;
   logic [7:0]  stat_drop_q;

   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB) begin
         stat_acc_q  <= '0;
         stat_drop_q <= '0;
      end else begin
         if (fifo_push) begin
            stat_acc_q <= sat_inc16(stat_acc_q);
         end
         if ((state_q == ST_COMMIT) && commit_drop) begin
            stat_drop_q <= sat_inc8(stat_drop_q);
         end
      end
   end

   assign port_if.STAT_ACC  = stat_acc_q;
   assign port_if.STAT_DROP = stat_drop_q;
`endif

endmodule
